// File: rtl/pipeline_sequencer_pkg.sv
// Shared constants for the stage-2 control path: opcodes, R-type functs,
// sequencer state encoding and the sequencer control bundle.
package pipeline_sequencer_pkg;

  // Opcodes, instruction bits [15:12]
  localparam logic [3:0] OP_HALT  = 4'b0000;
  localparam logic [3:0] OP_JMP   = 4'b0001;
  localparam logic [3:0] OP_BGT   = 4'b0100;
  localparam logic [3:0] OP_BLT   = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_ANDI  = 4'b1000;
  localparam logic [3:0] OP_ORI   = 4'b1001;
  localparam logic [3:0] OP_LBU   = 4'b1010;
  localparam logic [3:0] OP_SB    = 4'b1011;
  localparam logic [3:0] OP_LW    = 4'b1100;
  localparam logic [3:0] OP_SW    = 4'b1101;
  localparam logic [3:0] OP_RTYPE = 4'b1111;

  // R-type funct, instruction bits [3:0]
  localparam logic [3:0] F_ADD  = 4'b0000;
  localparam logic [3:0] F_SUB  = 4'b0001;
  localparam logic [3:0] F_MOV  = 4'b0010;
  localparam logic [3:0] F_SWAP = 4'b0011;
  localparam logic [3:0] F_MUL  = 4'b0100;
  localparam logic [3:0] F_DIV  = 4'b0101;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    DRAIN   = 2'd2,
    HALT    = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic md_start;
    logic md_busy;
    logic halted;
  } seq_ctl_t;

  // Freeze PC and IF/ID, zero ID/EX control; also the reset-time output set.
  function automatic seq_ctl_t ctl_stall();
    seq_ctl_t c;
    c             = '0;
    c.idex_bubble = 1'b1;
    return c;
  endfunction

  // Normal advance: fetch continues and ID flows into EX.
  function automatic seq_ctl_t ctl_run();
    seq_ctl_t c;
    c            = '0;
    c.pc_write   = 1'b1;
    c.ifid_write = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_sequencer_load_use_detect.sv
// Load-use hazard: does the ID instruction read the register an EX load writes?
module load_use_detect
  import pipeline_sequencer_pkg::*;
(
  input  logic       id_valid,
  input  logic [3:0] id_opcode,
  input  logic [3:0] id_rs1,
  input  logic [3:0] id_rs2,
  input  logic       ex_memRead,
  input  logic [3:0] ex_rd,
  output logic       load_use
);

  logic use_rs1, use_rs2;

  // Source-field usage per opcode; register 0 gets no special treatment.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (id_opcode)
      OP_RTYPE, OP_SB, OP_SW, OP_BGT, OP_BLT, OP_BEQ: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_LBU, OP_LW: use_rs1 = 1'b1;
      default: ;
    endcase
    load_use = id_valid & ex_memRead &
               ((use_rs1 & (id_rs1 == ex_rd)) | (use_rs2 & (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush/halt sequencer beside the decode control unit. Outputs are
// combinational from state, cnt and the ID/EX inputs.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int MUL_LAT   = 4,
  parameter int DIV_LAT   = 8,
  parameter int DRAIN_CYC = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [3:0]  id_opcode,
  input  logic [3:0]  id_funct,
  input  logic [3:0]  id_rs1,
  input  logic [3:0]  id_rs2,
  input  logic        ex_memRead,
  input  logic [3:0]  ex_rd,
  input  logic        br_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        md_start,
  output logic        md_busy,
  output logic        halted,
  output logic [15:0] stall_count
);

  seq_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_count_q, stall_count_d;
  seq_ctl_t    ctl, ctl_out;
  logic        load_use, is_mul, is_div;

  load_use_detect u_lud (
    .id_valid   (id_valid),
    .id_opcode  (id_opcode),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_memRead (ex_memRead),
    .ex_rd      (ex_rd),
    .load_use   (load_use)
  );

  assign is_mul = (id_opcode == OP_RTYPE) && (id_funct == F_MUL);
  assign is_div = (id_opcode == OP_RTYPE) && (id_funct == F_DIV);

  // Next-state and control decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctl     = ctl_run();
    case (state_q)
      RUN: begin
        if (load_use) begin
          // Any taken branch waits one cycle and is re-evaluated.
          ctl = ctl_stall();
        end else if (id_valid && id_opcode == OP_HALT) begin
          ctl     = ctl_stall();
          cnt_d   = 4'(DRAIN_CYC - 1);
          state_d = DRAIN;
        end else if (id_valid && (is_mul || is_div)) begin
          ctl          = ctl_stall();
          ctl.md_start = 1'b1;
          cnt_d        = is_mul ? 4'(MUL_LAT - 1) : 4'(DIV_LAT - 1);
          state_d      = MD_WAIT;
        end else if (id_valid && br_taken) begin
          ctl.ifid_write = 1'b0;
          ctl.ifid_flush = 1'b1;
        end
      end
      MD_WAIT: begin
        // cnt==0 is the release cycle: the MUL/DIV leaves ID on this edge,
        // so returning to RUN cannot re-detect it.
        if (cnt_q != 4'd0) begin
          ctl   = ctl_stall();
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RUN;
        end
        ctl.md_busy = 1'b1;
      end
      DRAIN: begin
        // halted rises in the last drain cycle so it appears DRAIN_CYC
        // cycles after HALT was seen in ID.
        ctl = ctl_stall();
        if (cnt_q == 4'd0) begin
          ctl.halted = 1'b1;
          state_d    = HALT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        ctl        = ctl_stall();
        ctl.halted = 1'b1;
      end
    endcase
  end

  // Reset overrides the decoded controls immediately.
  always_comb begin
    ctl_out = rst_n ? ctl : ctl_stall();
  end

  assign pc_write    = ctl_out.pc_write;
  assign ifid_write  = ctl_out.ifid_write;
  assign ifid_flush  = ctl_out.ifid_flush;
  assign idex_bubble = ctl_out.idex_bubble;
  assign md_start    = ctl_out.md_start;
  assign md_busy     = ctl_out.md_busy;
  assign halted      = ctl_out.halted;
  assign stall_count = stall_count_q;

  // Saturating stall counter; HALT cycles are not counted.
  always_comb begin
    stall_count_d = stall_count_q;
    if (!ctl.pc_write && state_q != HALT && stall_count_q != 16'hFFFF)
      stall_count_d = stall_count_q + 16'd1;
  end

  // State, shared down-counter and stall counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      cnt_q         <= 4'd0;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: directed table, corner sequences, and
// randomized traffic against a cycles-remaining reference model.
module tb_pipeline_sequencer;

  localparam int MUL_LAT   = 4;
  localparam int DIV_LAT   = 8;
  localparam int DRAIN_CYC = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, ex_memRead, br_taken;
  logic [3:0]  id_opcode, id_funct, id_rs1, id_rs2, ex_rd;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, md_start, md_busy, halted;
  logic [15:0] stall_count;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: cycles left in a MUL/DIV occupancy (stalls + release),
  // cycles left in the HALT drain, halted flag, stall tally.
  int m_md = 0;
  int m_dr = 0;
  bit m_h  = 0;
  int m_cnt = 0;

  pipeline_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_memRead(ex_memRead),
    .ex_rd(ex_rd), .br_taken(br_taken), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .md_start(md_start),
    .md_busy(md_busy), .halted(halted), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] fn,
                       input logic [3:0] r1, input logic [3:0] r2, input logic mr,
                       input logic [3:0] rd, input logic br);
    id_valid = v; id_opcode = op; id_funct = fn; id_rs1 = r1; id_rs2 = r2;
    ex_memRead = mr; ex_rd = rd; br_taken = br;
  endtask

  function automatic bit src_hit(input logic [3:0] op, input logic [3:0] r1,
                                 input logic [3:0] r2, input logic [3:0] rd);
    bit u1, u2;
    u1 = 0; u2 = 0;
    case (op)
      4'hF, 4'hB, 4'hD, 4'h4, 4'h5, 4'h6: begin u1 = 1; u2 = 1; end
      4'h8, 4'h9, 4'hA, 4'hC:             u1 = 1;
      default: ;
    endcase
    return (u1 && r1 == rd) || (u2 && r2 == rd);
  endfunction

  task automatic model_clear();
    m_md = 0; m_dr = 0; m_h = 0; m_cnt = 0;
  endtask

  // Called just after a negedge with inputs applied; checks, then crosses one edge.
  task automatic step();
    bit stall, e_fl, e_st, e_busy, e_hl, lu, n_h;
    int n_md, n_dr;
    n_md = m_md; n_dr = m_dr; n_h = m_h;
    stall = 0; e_fl = 0; e_st = 0; e_busy = 0; e_hl = 0;
    lu = id_valid && ex_memRead && src_hit(id_opcode, id_rs1, id_rs2, ex_rd);
    if (m_h) begin
      stall = 1; e_hl = 1;
    end else if (m_dr > 0) begin
      stall = 1; e_hl = (m_dr == 1); n_dr = m_dr - 1; n_h = (m_dr == 1);
    end else if (m_md > 0) begin
      e_busy = 1; stall = (m_md > 1); n_md = m_md - 1;
    end else if (lu) begin
      stall = 1;
    end else if (id_valid && id_opcode == 4'h0) begin
      stall = 1; n_dr = DRAIN_CYC;
    end else if (id_valid && id_opcode == 4'hF && (id_funct == 4'h4 || id_funct == 4'h5)) begin
      stall = 1; e_st = 1; n_md = (id_funct == 4'h4) ? MUL_LAT : DIV_LAT;
    end else if (id_valid && br_taken) begin
      e_fl = 1;
    end
    #1;
    chk("pc_write", pc_write, !stall);
    chk("ifid_write", ifid_write, !stall && !e_fl);
    chk("ifid_flush", ifid_flush, e_fl);
    chk("idex_bubble", idex_bubble, stall);
    chk("md_start", md_start, e_st);
    chk("md_busy", md_busy, e_busy);
    chk("halted", halted, e_hl);
    chk("stall_count", stall_count, m_cnt);
    if (stall && !m_h && m_cnt < 65535) m_cnt++;
    m_md = n_md; m_dr = n_dr; m_h = n_h;
    @(negedge clk);
  endtask

  // Asserts reset now, checks the forced outputs, releases on the next negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_pc_write", pc_write, 0);
    chk("rst_ifid_write", ifid_write, 0);
    chk("rst_ifid_flush", ifid_flush, 0);
    chk("rst_idex_bubble", idex_bubble, 1);
    chk("rst_md_start", md_start, 0);
    chk("rst_md_busy", md_busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stall_count", stall_count, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    string      nm;
    logic       v;
    logic [3:0] op, fn, r1, r2;
    logic       mr;
    logic [3:0] rd;
    logic       br;
    logic [4:0] exp;   // {pc_write, ifid_write, ifid_flush, idex_bubble, md_start}
  } vec_t;

  vec_t vt[16];

  initial begin
    int pc0, busy_n, st_n;
    vt[0]  = '{"ld_use_add_rs2",   1, 4'hF, 4'h0, 4'h1, 4'h3, 1, 4'h3, 0, 5'b00010};
    vt[1]  = '{"andi_rs2_unused",  1, 4'h8, 4'h0, 4'h5, 4'h3, 1, 4'h3, 0, 5'b11000};
    vt[2]  = '{"beq_taken",        1, 4'h6, 4'h0, 4'h1, 4'h2, 0, 4'h1, 1, 5'b10100};
    vt[3]  = '{"beq_taken_lu_rs1", 1, 4'h6, 4'h0, 4'h3, 4'h2, 1, 4'h3, 1, 5'b00010};
    vt[4]  = '{"halt",             1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b00010};
    vt[5]  = '{"mul",              1, 4'hF, 4'h4, 4'h1, 4'h2, 0, 4'h0, 0, 5'b00011};
    vt[6]  = '{"div",              1, 4'hF, 4'h5, 4'h1, 4'h2, 0, 4'h0, 0, 5'b00011};
    vt[7]  = '{"invalid_ignored",  0, 4'hF, 4'h4, 4'h3, 4'h3, 1, 4'h3, 1, 5'b11000};
    vt[8]  = '{"jmp_no_sources",   1, 4'h1, 4'h0, 4'h3, 4'h3, 1, 4'h3, 1, 5'b10100};
    vt[9]  = '{"sw_rs2",           1, 4'hD, 4'h0, 4'h1, 4'h7, 1, 4'h7, 0, 5'b00010};
    vt[10] = '{"lw_r0",            1, 4'hC, 4'h0, 4'h0, 4'h9, 1, 4'h0, 0, 5'b00010};
    vt[11] = '{"add_no_load",      1, 4'hF, 4'h0, 4'h3, 4'h3, 0, 4'h3, 0, 5'b11000};
    vt[12] = '{"mul_lu_first",     1, 4'hF, 4'h4, 4'h3, 4'h1, 1, 4'h3, 0, 5'b00010};
    vt[13] = '{"bgt_not_mul",      1, 4'h4, 4'h4, 4'h1, 4'h2, 0, 4'h3, 0, 5'b11000};
    vt[14] = '{"halt_invalid",     0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b11000};
    vt[15] = '{"lbu_rs1_br",       1, 4'hA, 4'h0, 4'h9, 4'h1, 1, 4'h9, 1, 5'b00010};

    // Reset state with a taken branch on the inputs: reset values must win.
    rst_n = 1'b0;
    drive(1, 4'h6, 4'h0, 4'h1, 4'h2, 0, 4'h0, 1);
    @(negedge clk);
    do_reset();

    // Table: single RUN-state decisions; reset held across each edge keeps RUN.
    foreach (vt[i]) begin
      drive(vt[i].v, vt[i].op, vt[i].fn, vt[i].r1, vt[i].r2, vt[i].mr, vt[i].rd, vt[i].br);
      #1;
      chk(vt[i].nm, {pc_write, ifid_write, ifid_flush, idex_bubble, md_start, md_busy, halted},
          {vt[i].exp, 2'b00});
      rst_n = 1'b0;
      drive(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0);
      @(negedge clk);
      rst_n = 1'b1;
    end
    model_clear();

    // MUL: exactly MUL_LAT stall cycles, one start pulse, MUL_LAT busy cycles.
    pc0 = 0; busy_n = 0; st_n = 0;
    for (int i = 0; i <= MUL_LAT; i++) begin
      drive(1, 4'hF, 4'h4, 4'h1, 4'h2, 0, 4'h0, 0);
      #1;
      pc0 += !pc_write; busy_n += md_busy; st_n += md_start;
      step();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 4'hF, 4'h0, 4'h1, 4'h2, 0, 4'h0, 0);
      #1;
      pc0 += !pc_write; busy_n += md_busy; st_n += md_start;
      step();
    end
    chk("mul_stall_cycles", pc0, MUL_LAT);
    chk("mul_busy_cycles", busy_n, MUL_LAT);
    chk("mul_start_pulses", st_n, 1);
    chk("mul_stall_count", stall_count, 4);

    // DIV: DIV_LAT stall cycles, counter continues from 4.
    pc0 = 0;
    for (int i = 0; i <= DIV_LAT; i++) begin
      drive(1, 4'hF, 4'h5, 4'h1, 4'h2, 0, 4'h0, 0);
      #1;
      pc0 += !pc_write;
      step();
    end
    drive(1, 4'hF, 4'h0, 4'h1, 4'h2, 0, 4'h0, 0);
    step();
    chk("div_stall_cycles", pc0, DIV_LAT);
    chk("div_stall_count", stall_count, 12);

    // Taken branch blocked by load-use, then flushed once the load has moved on.
    drive(1, 4'h6, 4'h0, 4'h3, 4'h2, 1, 4'h3, 1);
    #1;
    chk("br_lu_no_flush", ifid_flush, 0);
    step();
    drive(1, 4'h6, 4'h0, 4'h3, 4'h2, 0, 4'h3, 1);
    #1;
    chk("br_after_lu_flush", ifid_flush, 1);
    step();

    // Reset in MD_WAIT with two stall cycles still to go.
    drive(1, 4'hF, 4'h4, 4'h1, 4'h2, 0, 4'h0, 0);
    step();
    step();
    #1;
    chk("md_wait_busy_pre_rst", md_busy, 1);
    do_reset();
    drive(1, 4'hF, 4'h0, 4'h1, 4'h2, 0, 4'h0, 0);
    #1;
    chk("post_rst_run", pc_write, 1);
    step();
    chk("post_rst_stall_count", stall_count, 0);

    // HALT: halted from DRAIN_CYC cycles after detection; inputs then ignored.
    for (int i = 0; i < 10; i++) begin
      if (i == 0) drive(1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0);
      else        drive(1, 4'(i), 4'h4, 4'h3, 4'h3, 1, 4'h3, 1);
      #1;
      chk("halt_timeline", halted, i >= DRAIN_CYC);
      step();
    end
    chk("halt_stall_count", stall_count, 1 + DRAIN_CYC);

    // Saturation: hold a load-use until the counter pins at FFFF.
    do_reset();
    drive(1, 4'hF, 4'h0, 4'h3, 4'h1, 1, 4'h3, 0);
    for (int i = 0; i < 65534; i++) step();
    #1;
    chk("sat_fffe", stall_count, 16'hFFFE);
    for (int i = 0; i < 3; i++) step();
    #1;
    chk("sat_ffff", stall_count, 16'hFFFF);

    // Randomized traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] op;
      if ((m_h && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) do_reset();
      op = 4'($urandom_range(0, 15));
      if (op == 4'h0 && $urandom_range(0, 7) != 0) op = 4'h1;
      drive(1'($urandom_range(0, 7) != 0), op, 4'($urandom_range(0, 7)),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
